// File: rtl/mips32_mem_pkg.sv
// Shared types for the MIPS32 data-memory path: load-op codes, load FSM states,
// big-endian byte-lane offsets and small decode helpers.
package mips32_mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } load_state_e;

  // Byte offset within a big-endian word: offset 0 is the most significant byte.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU: return off[0];
      OP_LW:         return off != LANE_B0;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, data-memory and response signals of the load unit.
// master = requester/memory side, slave = the load unit itself.
interface load_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        req_rt;

  logic              mem_rd_en;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [4:0]        rsp_rt;
  logic              rsp_error;

  modport master (
    output req_valid, req_op, req_addr, req_rt, mem_rvalid, mem_rdata,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_rt, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_rt, mem_rvalid, mem_rdata,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_rt, rsp_error
  );
endinterface

// File: rtl/load_extract.sv
// Combinational big-endian lane select plus sign/zero extension for MIPS32 loads.
// Zero latency; no flow control.
module load_extract
  import mips32_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[31:24];
    case (offset)
      LANE_B1: lane_b = word[23:16];
      LANE_B2: lane_b = word[15:8];
      LANE_B3: lane_b = word[7:0];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    data = word;
    case (op)
      OP_LB:   data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  data = {24'd0, lane_b};
      OP_LH:   data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  data = {16'd0, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding MIPS32 load: one word read, lane extract, registered response (min 3 cycles).
// req_ready only in IDLE; watchdog errors a missing reply. LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW.
module load_unit
  import mips32_mem_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic        CLK,
  input logic        reset,
  load_unit_if.slave bus
);

  load_state_e       state_q;
  logic [2:0]        op_q;
  logic [1:0]        off_q;
  logic [4:0]        rt_q;
  logic [31:0]       wdog_q;
  logic              req_ready_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [4:0]        rsp_rt_q;
  logic              rsp_error_q;

  logic [31:0]       ext_data;
  logic              acc_err;
  logic              wd_expired;

  load_extract u_extract (
    .op     (op_q),
    .offset (off_q),
    .word   (bus.mem_rdata),
    .data   (ext_data)
  );

  always_comb begin
    acc_err = !is_legal_op(bus.req_op);
`ifdef LOAD_MISALIGN_TRAP_EN
    acc_err = acc_err || is_misaligned(bus.req_op, bus.req_addr[1:0]);
`endif
  end

  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      rt_q        <= 5'd0;
      wdog_q      <= 32'd0;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_rt_q    <= 5'd0;
      rsp_error_q <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            off_q       <= bus.req_addr[1:0];
            rt_q        <= bus.req_rt;
            req_ready_q <= 1'b0;
            if (acc_err) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= 32'd0;
              rsp_rt_q    <= bus.req_rt;
            end else begin
              state_q     <= S_REQ;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
            end
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
          wdog_q  <= 32'd0;
        end
        S_WAIT: begin
          // A reply on the expiry cycle still wins over the timeout.
          if (bus.mem_rvalid) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= ext_data;
            rsp_rt_q    <= rt_q;
          end else if (wd_expired) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_data_q  <= 32'd0;
            rsp_rt_q    <= rt_q;
          end else if (TIMEOUT_CYCLES != 0) begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rt    = rsp_rt_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
